// File: rtl/bit_serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package bit_serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bit_serial_adder_full_adder_cell.sv
// One-bit gate-level full adder; the adder twin of the subtractor cell.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-adder cell plus a carry flop,
// WIDTH cycles per operation with a start/busy/done handshake.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             bit_s;
    logic             bit_co;

    full_adder_cell u_fa (
        .a   (op_a[0]),
        .b   (op_b[0]),
        .cin (carry),
        .s   (bit_s),
        .co  (bit_co)
    );

    // Controller, operand shifters, result shifter and carry in one process
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= bit_co;
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    sum   <= {bit_s, sum[WIDTH-1:1]};
                    cnt   <= cnt + CW'(1);
                    // Last bit: the carry out of this cell is the final carry
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout  <= bit_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
